// File: rtl/ascon_absorb_stage_if.sv
// Handshake bundle for the Ascon absorb/key-injection stage: command, data-block and result channels.
// valid/ready: a transfer happens on a rising clock edge where both are high; the sender holds valid and payload steady until then.
interface ascon_absorb_stage_if #(
  parameter int RATE_W = 64,
  parameter int NB_W   = $clog2(RATE_W / 8) + 1
);
  typedef logic [4:0][63:0] type_state;  // [0] = x0 ... [4] = x4

  logic              cmd_valid_i;
  logic              cmd_ready_o;
  logic [1:0]        mode_i;
  logic              decrypt_i;
  logic              dsep_i;
  logic [127:0]      key_i;
  type_state         registerS_i;
  logic [RATE_W-1:0] data_i;
  logic              data_valid_i;
  logic              data_ready_o;
  logic              data_last_i;
  logic [NB_W-1:0]   data_bytes_i;
  type_state         registerS_o;
  logic              state_valid_o;
  logic              state_ready_i;
  logic [RATE_W-1:0] text_o;
  logic              pad_pending_o;

  modport slave (
    input  cmd_valid_i, mode_i, decrypt_i, dsep_i, key_i, registerS_i,
    input  data_i, data_valid_i, data_last_i, data_bytes_i, state_ready_i,
    output cmd_ready_o, data_ready_o, registerS_o, state_valid_o, text_o, pad_pending_o
  );

  modport master (
    output cmd_valid_i, mode_i, decrypt_i, dsep_i, key_i, registerS_i,
    output data_i, data_valid_i, data_last_i, data_bytes_i, state_ready_i,
    input  cmd_ready_o, data_ready_o, registerS_o, state_valid_o, text_o, pad_pending_o
  );
endinterface

// File: rtl/ascon_absorb_stage.sv
// Registered Ascon state-injection stage: encrypt/decrypt absorb with 10* padding, deferred pad block,
// key injection at init/final and domain separation, sitting between the state register and the permutation.
module ascon_absorb_stage #(
  parameter int RATE_W = 64,
  parameter int NB_W   = $clog2(RATE_W / 8) + 1
) (
  input  logic                 clock_i,
  input  logic                 resetb_i,
  ascon_absorb_stage_if.slave  bus,
  output logic [1:0]           state_dbg
);
  localparam int NBYTES = RATE_W / 8;
  localparam int RWORDS = RATE_W / 64;

  localparam logic [1:0] MODE_PASS      = 2'b00;
  localparam logic [1:0] MODE_ABSORB    = 2'b01;
  localparam logic [1:0] MODE_FINAL_KEY = 2'b10;
  localparam logic [1:0] MODE_INIT_KEY  = 2'b11;

  localparam logic [RATE_W-1:0] PAD_FIRST = {8'h80, {(RATE_W - 8){1'b0}}};

  typedef logic [4:0][63:0] state_t;
  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_DATA = 2'd1,
    S_OUT       = 2'd2
  } fsm_t;

  if (RATE_W != 64 && RATE_W != 128) begin : g_bad_rate
    $error("ascon_absorb_stage: RATE_W must be 64 or 128");
  end

  fsm_t              state_q, state_d;
  logic              cmd_fire, data_fire, go_wait, load_out;

  state_t            st_q;
  logic [1:0]        mode_q;
  logic              dec_q, dsep_q, pend_q;
  logic [127:0]      key_q;
  state_t            out_q;
  logic [RATE_W-1:0] text_q;

  logic              in_wait;
  state_t            op_st;
  logic [1:0]        op_mode;
  logic              op_dec, op_dsep;
  logic [127:0]      op_key;

  logic [NB_W-1:0]   n_sat, n_eff;
  logic [RATE_W-1:0] mask, pad, rate, res_rate, res_text;
  state_t            res_st;
  logic              res_pend;

  // ---------------- control FSM ----------------
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d           = state_q;
    bus.cmd_ready_o   = 1'b0;
    bus.data_ready_o  = 1'b0;
    bus.state_valid_o = 1'b0;
    cmd_fire          = 1'b0;
    data_fire         = 1'b0;
    go_wait           = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        bus.cmd_ready_o = 1'b1;
        if (bus.cmd_valid_i) begin
          cmd_fire = 1'b1;
          // A pending pad block is emitted without asking for data.
          go_wait  = (bus.mode_i == MODE_ABSORB) && !pend_q;
          state_d  = go_wait ? S_WAIT_DATA : S_OUT;
        end
      end
      S_WAIT_DATA: begin
        bus.data_ready_o = 1'b1;
        if (bus.data_valid_i) begin
          data_fire = 1'b1;
          state_d   = S_OUT;
        end
      end
      S_OUT: begin
        bus.state_valid_o = 1'b1;
        if (bus.state_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign load_out  = (cmd_fire && !go_wait) || data_fire;
  assign state_dbg = state_q;

  // ---------------- operand selection ----------------
  // Commands that finish at accept use the live inputs; data absorbs use the captured copy.
  assign in_wait = (state_q == S_WAIT_DATA);
  assign op_st   = in_wait ? st_q   : bus.registerS_i;
  assign op_mode = in_wait ? mode_q : bus.mode_i;
  assign op_dec  = in_wait ? dec_q  : bus.decrypt_i;
  assign op_dsep = in_wait ? dsep_q : bus.dsep_i;
  assign op_key  = in_wait ? key_q  : bus.key_i;

  // ---------------- byte mask and pad ----------------
  assign n_sat = (bus.data_bytes_i > NB_W'(NBYTES)) ? NB_W'(NBYTES) : bus.data_bytes_i;
  assign n_eff = bus.data_last_i ? n_sat : NB_W'(NBYTES);

  always_comb begin
    mask = '0;
    pad  = '0;
    for (int i = 0; i < NBYTES; i++) begin
      if (NB_W'(i) < n_eff) mask[RATE_W-1-8*i -: 8] = 8'hFF;
      if (bus.data_last_i && (NB_W'(i) == n_eff)) pad[RATE_W-1-8*i -: 8] = 8'h80;
    end
  end

  always_comb begin
    rate = '0;
    for (int w = 0; w < RWORDS; w++) rate[RATE_W-1-64*w -: 64] = op_st[w];
  end

  // ---------------- state update ----------------
  always_comb begin
    res_rate = rate;
    res_text = '0;
    res_st   = op_st;
    res_pend = pend_q;
    unique case (op_mode)
      MODE_PASS: ;
      MODE_ABSORB: begin
        if (!in_wait) begin
          res_rate = rate ^ PAD_FIRST;
          res_pend = 1'b0;
        end else begin
          if (op_dec) begin
            res_text = (rate ^ bus.data_i) & mask;
            res_rate = (bus.data_i & mask) | ((rate & ~mask) ^ pad);
          end else begin
            res_rate = rate ^ (bus.data_i & mask) ^ pad;
            res_text = res_rate & mask;
          end
          // A full final block has no room for the pad byte; it is owed as a separate block.
          res_pend = bus.data_last_i && (n_eff == NB_W'(NBYTES));
        end
      end
      MODE_FINAL_KEY: begin
        res_st[RWORDS]     = op_st[RWORDS] ^ op_key[127:64];
        res_st[RWORDS + 1] = op_st[RWORDS + 1] ^ op_key[63:0];
      end
      MODE_INIT_KEY: begin
        res_st[3] = op_st[3] ^ op_key[127:64];
        res_st[4] = op_st[4] ^ op_key[63:0];
        res_pend  = 1'b0;
      end
      default: ;
    endcase
    for (int w = 0; w < RWORDS; w++) res_st[w] = res_rate[RATE_W-1-64*w -: 64];
    res_st[4][0] = res_st[4][0] ^ op_dsep;
  end

  // ---------------- registers ----------------
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      st_q   <= '0;
      mode_q <= MODE_PASS;
      dec_q  <= 1'b0;
      dsep_q <= 1'b0;
      key_q  <= '0;
      pend_q <= 1'b0;
      out_q  <= '0;
      text_q <= '0;
    end else begin
      if (cmd_fire) begin
        st_q   <= bus.registerS_i;
        mode_q <= bus.mode_i;
        dec_q  <= bus.decrypt_i;
        dsep_q <= bus.dsep_i;
        key_q  <= bus.key_i;
      end
      if (load_out) begin
        out_q  <= res_st;
        text_q <= res_text;
        pend_q <= res_pend;
      end
    end
  end

  assign bus.registerS_o   = out_q;
  assign bus.text_o        = text_q;
  assign bus.pad_pending_o = pend_q;
endmodule
